// File: rtl/serial_input_receiver_register.sv
// ============================================================================
// Module      : serial_input_receiver_register
// Description : Serial-in / parallel-out receiver with valid/ack handshake
//               and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_input_receiver_register #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sin,
  input  logic                     ack,
  output logic [WIDTH-1:0]         p_out,
  output logic                     valid,
  output logic                     overrun,
  output logic [WIDTH-1:0]         status,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [WIDTH-1:0]   r_status;
  logic [WIDTH-1:0]   r_p_out;
  logic               r_valid;
  logic               r_overrun;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   w_shift;
  logic               w_done;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shift = {sin, r_status[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shift = {r_status[WIDTH-2:0], sin};
    end
  endgenerate

  // The explicit wrap keeps non-power-of-2 widths correct.
  assign w_done = en && (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status  <= '0;
      r_p_out   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (en) begin
        r_status <= w_shift;
        r_cnt    <= w_done ? '0 : r_cnt + c_ONE;
      end
      if (w_done) begin
        r_p_out <= w_shift;
        r_valid <= 1'b1;
        if (r_valid && !ack) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign p_out   = r_p_out;
  assign valid   = r_valid;
  assign overrun = r_overrun;
  assign status  = r_status;
  assign bit_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_serial_input_receiver_register.sv
// ============================================================================
// Module      : tb_serial_input_receiver_register
// Description : Directed bench for both bit orders with a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_input_receiver_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       sin = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] p_out_l, status_l, p_out_m, status_m;
  logic       valid_l, overrun_l, valid_m, overrun_m;
  logic [2:0] cnt_l, cnt_m;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q_l[$];
  logic [7:0] q_m[$];

  always #5 clk = ~clk;

  serial_input_receiver_register #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .ack(ack),
    .p_out(p_out_l), .valid(valid_l), .overrun(overrun_l),
    .status(status_l), .bit_cnt(cnt_l)
  );

  serial_input_receiver_register #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .ack(ack),
    .p_out(p_out_m), .valid(valid_m), .overrun(overrun_m),
    .status(status_m), .bit_cnt(cnt_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // The LSB-first stream of w lands bit-reversed in the MSB-first receiver.
  task automatic expect_word(input logic [7:0] w);
    q_l.push_back(w);
    q_m.push_back(rev8(w));
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input logic ack_last);
    for (int i = lo; i <= hi; i++) begin
      en  = 1'b1;
      sin = w[i];
      ack = ack_last && (i == 7);
      tick();
    end
    en  = 1'b0;
    ack = 1'b0;
  endtask

  task automatic check_word(input string tag);
    logic [7:0] e;
    if (q_l.size() == 0 || q_m.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q_l.pop_front();
      chk({tag, "_pout_lsb"}, {24'd0, p_out_l}, {24'd0, e});
      e = q_m.pop_front();
      chk({tag, "_pout_msb"}, {24'd0, p_out_m}, {24'd0, e});
    end
    chk({tag, "_valid"}, {31'd0, valid_l}, 32'd1);
    chk({tag, "_cnt"}, {29'd0, cnt_l}, 32'd0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_status"},  {24'd0, status_l},  32'd0);
    chk({tag, "_pout"},    {24'd0, p_out_l},   32'd0);
    chk({tag, "_valid"},   {31'd0, valid_l},   32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun_l}, 32'd0);
    chk({tag, "_cnt"},     {29'd0, cnt_l},     32'd0);
    chk({tag, "_pout_m"},  {24'd0, p_out_m},   32'd0);
  endtask

  initial begin
    logic [7:0] tx;

    // Reset with en and sin active
    rst = 1'b1; en = 1'b1; sin = 1'b1;
    tick(); tick();
    rst = 1'b0; en = 1'b0; sin = 1'b0;
    check_zero("reset");

    // Basic receive: stream 0,1,0,0,1,0,0,1
    expect_word(8'b1001_0010);
    send_bits(8'b1001_0010, 0, 7, 1'b0);
    check_word("basic");
    chk("basic_status", {24'd0, status_l}, 32'h92);
    chk("basic_pout_m_literal", {24'd0, p_out_m}, 32'h49);
    do_ack();
    chk("basic_ack_valid", {31'd0, valid_l}, 32'd0);
    chk("basic_ack_hold", {24'd0, p_out_l}, 32'h92);
    do_ack();
    chk("ack_idle_valid", {31'd0, valid_l}, 32'd0);

    // Loopback from a transmitter model: load p_in, then shift out LSB first
    tx = 8'b1001_0010;
    tick();
    expect_word(8'b1001_0010);
    for (int i = 0; i < 8; i++) begin
      en  = 1'b1;
      sin = tx[0];
      tick();
      tx  = {1'b0, tx[7:1]};
    end
    en = 1'b0;
    check_word("loop");
    do_ack();

    // Gaps: en low for 3 cycles after bit 4
    expect_word(8'h92);
    send_bits(8'h92, 0, 3, 1'b0);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap_cnt", {29'd0, cnt_l}, 32'd4);
    end
    chk("gap_valid", {31'd0, valid_l}, 32'd0);
    send_bits(8'h92, 4, 7, 1'b0);
    check_word("gap");
    do_ack();

    // Back-to-back, ack on the completing edge of the second word
    expect_word(8'hA5);
    send_bits(8'hA5, 0, 7, 1'b0);
    check_word("b2b_first");
    expect_word(8'h3C);
    send_bits(8'h3C, 0, 7, 1'b1);
    check_word("b2b_second");
    chk("b2b_overrun", {31'd0, overrun_l}, 32'd0);
    do_ack();

    // Overrun: second word completes with no ack
    expect_word(8'hA5);
    send_bits(8'hA5, 0, 7, 1'b0);
    check_word("ovr_first");
    expect_word(8'hFF);
    send_bits(8'hFF, 0, 7, 1'b0);
    check_word("ovr_second");
    chk("ovr_flag", {31'd0, overrun_l}, 32'd1);
    do_ack();
    chk("ovr_sticky", {31'd0, overrun_l}, 32'd1);
    chk("ovr_ack_valid", {31'd0, valid_l}, 32'd0);

    // Reset mid-way through a third word
    send_bits(8'h5A, 0, 2, 1'b0);
    chk("mid_cnt", {29'd0, cnt_l}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midrst");
    chk("queue_drained", q_l.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
